// File: rtl/vector_line_draw.sv
// Bresenham segment rasteriser driving the x/y DAC channels of the vector display.
// Segments are accepted in IDLE, set up for one cycle, then walked one point per enable tick.
module vector_line_draw #(
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 seg_valid,
    output logic                 seg_ready,
    input  logic [OUT_WIDTH-1:0] x0_in,
    input  logic [OUT_WIDTH-1:0] y0_in,
    input  logic [OUT_WIDTH-1:0] x1_in,
    input  logic [OUT_WIDTH-1:0] y1_in,
    output logic [OUT_WIDTH-1:0] x_out,
    output logic [OUT_WIDTH-1:0] y_out,
    output logic                 busy,
    output logic                 done
);
    localparam int SW = OUT_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, SETUP, DRAW} state_t;

    state_t                 state_q, state_d;
    logic [OUT_WIDTH-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [OUT_WIDTH-1:0]   x_q, x_d, y_q, y_d;
    logic signed [SW-1:0]   dx_q, dx_d, dy_q, dy_d, err_q, err_d;
    logic                   sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;
    logic                   done_q, done_d;

    logic [OUT_WIDTH-1:0]   abs_x, abs_y;
    logic signed [SW:0]     e2, dx_ext, dy_ext;
    logic signed [SW-1:0]   err_n;

    always_comb begin
        abs_x  = (x1_q >= x0_q) ? x1_q - x0_q : x0_q - x1_q;
        abs_y  = (y1_q >= y0_q) ? y1_q - y0_q : y0_q - y1_q;
        e2     = {err_q, 1'b0};
        dx_ext = {dx_q[SW-1], dx_q};
        dy_ext = {dy_q[SW-1], dy_q};
        err_n  = err_q;

        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x_d      = x_q;
        y_d      = y_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        err_d    = err_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (seg_valid) begin
                    x0_d    = x0_in;
                    y0_d    = y0_in;
                    x1_d    = x1_in;
                    y1_d    = y1_in;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                dx_d     = $signed({2'b00, abs_x});
                dy_d     = -$signed({2'b00, abs_y});
                err_d    = $signed({2'b00, abs_x}) - $signed({2'b00, abs_y});
                sx_neg_d = !(x0_q < x1_q);
                sy_neg_d = !(y0_q < y1_q);
                x_d      = x0_q;
                y_d      = y0_q;
                state_d  = DRAW;
            end
            DRAW: begin
                if (enable) begin
                    if (x_q == x1_q && y_q == y1_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Both tests use the pre-step e2 so a diagonal step applies dx and dy together.
                        if (e2 >= dy_ext) begin
                            err_n = err_n + dy_q;
                            x_d   = sx_neg_q ? x_q - 1'b1 : x_q + 1'b1;
                        end
                        if (e2 <= dx_ext) begin
                            err_n = err_n + dx_q;
                            y_d   = sy_neg_q ? y_q - 1'b1 : y_q + 1'b1;
                        end
                        err_d = err_n;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            x1_q     <= '0;
            y1_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            err_q    <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            x1_q     <= x1_d;
            y1_q     <= y1_d;
            x_q      <= x_d;
            y_q      <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            err_q    <= err_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
            done_q   <= done_d;
        end
    end

    assign seg_ready = (state_q == IDLE) && !rst;
    assign busy      = (state_q != IDLE);
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign done      = done_q;
endmodule

// File: tb/tb_vector_line_draw.sv
// Directed bench for vector_line_draw: hand-derived point sequences, pacing, back-to-back and reset cases.
module tb_vector_line_draw;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, enable, seg_valid, seg_ready, busy, done;
    logic [W-1:0] x0_in, y0_in, x1_in, y1_in, x_out, y_out;

    int errors = 0;
    int checks = 0;
    int xe[256];
    int ye[256];

    always #5 clk = ~clk;

    vector_line_draw #(.OUT_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .seg_valid(seg_valid), .seg_ready(seg_ready),
        .x0_in(x0_in), .y0_in(y0_in), .x1_in(x1_in), .y1_in(y1_in),
        .x_out(x_out), .y_out(y_out), .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seg(input int ax0, input int ay0, input int ax1, input int ay1);
        x0_in = W'(ax0);
        y0_in = W'(ay0);
        x1_in = W'(ax1);
        y1_in = W'(ay1);
    endtask

    // Drives one segment with enable high and compares against xe/ye[0..n-1].
    task automatic run_line(input string tag, input int ax0, input int ay0,
                            input int ax1, input int ay1, input int n);
        set_seg(ax0, ay0, ax1, ay1);
        seg_valid = 1'b1;
        check({tag, "_rdy_idle"}, 32'(seg_ready), 1);
        tick();
        seg_valid = 1'b0;
        check({tag, "_busy_setup"}, 32'(busy), 1);
        check({tag, "_rdy_setup"}, 32'(seg_ready), 0);
        tick();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s_x%0d", tag, k), 32'(x_out), 32'(xe[k]));
            check($sformatf("%s_y%0d", tag, k), 32'(y_out), 32'(ye[k]));
            check($sformatf("%s_nodone%0d", tag, k), 32'(done), 0);
            tick();
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_xend"}, 32'(x_out), 32'(ax1));
        check({tag, "_yend"}, 32'(y_out), 32'(ay1));
        check({tag, "_rdy_end"}, 32'(seg_ready), 1);
        check({tag, "_busy_end"}, 32'(busy), 0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; seg_valid = 1'b0;
        set_seg(0, 0, 0, 0);
        tick();
        tick();
        check("rst_x", 32'(x_out), 0);
        check("rst_y", 32'(y_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rdy", 32'(seg_ready), 0);
        rst = 1'b0;
        #1;
        check("rdy_after_rst", 32'(seg_ready), 1);
        enable = 1'b1;

        // Horizontal (0,5)->(4,5)
        for (int k = 0; k < 5; k++) begin xe[k] = k; ye[k] = 5; end
        run_line("horiz", 0, 5, 4, 5, 5);

        // Steep reversed (3,4)->(2,0): x moves once, on the second step
        xe[0] = 3; ye[0] = 4;
        xe[1] = 3; ye[1] = 3;
        xe[2] = 2; ye[2] = 2;
        xe[3] = 2; ye[3] = 1;
        xe[4] = 2; ye[4] = 0;
        run_line("steep", 3, 4, 2, 0, 5);

        // Diagonal (0,0)->(3,3) paced by enable every 10th cycle
        enable = 1'b0;
        set_seg(0, 0, 3, 3);
        seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 10; c++) begin
                check($sformatf("pace_x%0d_%0d", k, c), 32'(x_out), 32'(k));
                check($sformatf("pace_y%0d_%0d", k, c), 32'(y_out), 32'(k));
                check($sformatf("pace_busy%0d_%0d", k, c), 32'(busy), 1);
                check($sformatf("pace_nodone%0d_%0d", k, c), 32'(done), 0);
                enable = (c == 9);
                tick();
            end
        end
        enable = 1'b0;
        check("pace_done", 32'(done), 1);
        check("pace_busy_end", 32'(busy), 0);
        begin
            int extra = 0;
            for (int c = 0; c < 15; c++) begin
                tick();
                if (done) extra++;
            end
            check("pace_done_once", 32'(extra), 0);
        end
        enable = 1'b1;

        // Full-range anti-diagonal (0,255)->(255,0)
        for (int k = 0; k < 256; k++) begin xe[k] = k; ye[k] = 255 - k; end
        run_line("full", 0, 255, 255, 0, 256);

        // Degenerate (7,7)->(7,7) then (7,7)->(9,7) with seg_valid held
        set_seg(7, 7, 7, 7);
        seg_valid = 1'b1;
        tick();
        set_seg(7, 7, 9, 7);
        check("degen_busy", 32'(busy), 1);
        tick();
        check("degen_x", 32'(x_out), 7);
        check("degen_y", 32'(y_out), 7);
        check("degen_nodone", 32'(done), 0);
        tick();
        check("degen_done", 32'(done), 1);
        check("degen_rdy", 32'(seg_ready), 1);
        tick();
        seg_valid = 1'b0;
        check("b2b_accept", 32'(busy), 1);
        check("b2b_done_pulse", 32'(done), 0);
        tick();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("b2b_x%0d", k), 32'(x_out), 32'(7 + k));
            check($sformatf("b2b_y%0d", k), 32'(y_out), 7);
            tick();
        end
        check("b2b_done", 32'(done), 1);
        tick();

        // Reset while the second point of (0,0)->(6,0) is showing
        set_seg(0, 0, 6, 0);
        seg_valid = 1'b1;
        tick();
        seg_valid = 1'b0;
        tick();
        tick();
        check("rstmid_pt2", 32'(x_out), 1);
        rst = 1'b1;
        tick();
        check("rstmid_x", 32'(x_out), 0);
        check("rstmid_y", 32'(y_out), 0);
        check("rstmid_done", 32'(done), 0);
        check("rstmid_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();
        check("rstmid_rdy", 32'(seg_ready), 1);
        check("rstmid_nodone", 32'(done), 0);
        check("rstmid_xpark", 32'(x_out), 0);

        // (2,1)->(5,3) after the reset
        xe[0] = 2; ye[0] = 1;
        xe[1] = 3; ye[1] = 2;
        xe[2] = 4; ye[2] = 2;
        xe[3] = 5; ye[3] = 3;
        run_line("post", 2, 1, 5, 3, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
